// File: rtl/seg_led_ctrl.sv
// seg_led_ctrl: bus-mapped LED register plus a multiplexed seven-segment scan engine
// with hex decode, per-digit blank/dp masks, blink and selectable output polarity.
module seg_led_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_SCANS = 64,
    parameter int unsigned LED_W       = 8,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led_data,
    output logic [7:0]        segment_data,
    output logic [DIGITS-1:0] AN
);

    localparam int unsigned RW  = $clog2(REFRESH_DIV);
    localparam int unsigned SW  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam int unsigned VW  = 4 * DIGITS;
    localparam logic        INV = (ACTIVE_LOW != 0);

    localparam logic [1:0] A_LED    = 2'd0;
    localparam logic [1:0] A_VALUE  = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    logic [RW-1:0]     refresh_q, refresh_d;
    logic [2:0]        digit_q,   digit_d;
    logic [SW-1:0]     scan_q,    scan_d;
    logic              phase_q,   phase_d;
    logic [LED_W-1:0]  led_q,     led_d;
    logic [VW-1:0]     value_q,   value_d;
    logic              en_q,      en_d;
    logic              blink_q,   blink_d;
    logic [DIGITS-1:0] blank_q,   blank_d;
    logic [DIGITS-1:0] dp_q,      dp_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [DIGITS-1:0] an_q,      an_d;
    logic [7:0]        seg_q,     seg_d;

    logic [3:0]        nib_c;
    logic              blank_bit_c;
    logic              dp_bit_c;
    logic [DIGITS-1:0] sel_c;
    logic              lit_c;

    // Upper write-data bits beyond the configured widths are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Scan engine: refresh divider -> digit index -> scan counter -> blink phase.
    always_comb begin
        refresh_d = refresh_q + RW'(1);
        digit_d   = digit_q;
        scan_d    = scan_q;
        phase_d   = phase_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            if (digit_q == 3'(DIGITS - 1)) begin
                digit_d = '0;
                if (scan_q == SW'(BLINK_SCANS - 1)) begin
                    scan_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    scan_d = scan_q + SW'(1);
                end
            end else begin
                digit_d = digit_q + 3'd1;
            end
        end
    end

    // Register file writes; STATUS (addr 3) is read-only.
    always_comb begin
        led_d   = led_q;
        value_d = value_q;
        en_d    = en_q;
        blink_d = blink_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        if (we) begin
            case (addr)
                A_LED:   led_d   = wdata[LED_W-1:0];
                A_VALUE: value_d = wdata[VW-1:0];
                A_CTRL: begin
                    en_d    = wdata[0];
                    blink_d = wdata[1];
                    blank_d = wdata[8 +: DIGITS];
                    dp_d    = wdata[16 +: DIGITS];
                end
                default: ;
            endcase
        end
    end

    // Unconditional registered readback of the addressed register.
    always_comb begin
        case (addr)
            A_LED:   rdata_d = 32'(led_q);
            A_VALUE: rdata_d = 32'(value_q);
            A_CTRL:  rdata_d = {8'h00, 8'(dp_q), 8'(blank_q), 6'b0, blink_q, en_q};
            default: rdata_d = {28'b0, phase_q, digit_q};
        endcase
    end

    // Digit composition in active-high form, then polarity applied ahead of the output flops.
    always_comb begin
        nib_c       = 4'h0;
        blank_bit_c = 1'b0;
        dp_bit_c    = 1'b0;
        sel_c       = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_q == 3'(i)) begin
                nib_c       = value_q[4*i +: 4];
                blank_bit_c = blank_q[i];
                dp_bit_c    = dp_q[i];
                sel_c[i]    = 1'b1;
            end
        end
        lit_c = en_q & ~blank_bit_c & ~(blink_q & phase_q);
        an_d  = (lit_c ? sel_c : '0) ^ {DIGITS{INV}};
        seg_d = (lit_c ? {dp_bit_c, hex7(nib_c)} : 8'h00) ^ {8{INV}};
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_q <= '0;
            digit_q   <= '0;
            scan_q    <= '0;
            phase_q   <= 1'b0;
            led_q     <= '0;
            value_q   <= '0;
            en_q      <= 1'b1;
            blink_q   <= 1'b0;
            blank_q   <= '0;
            dp_q      <= '0;
            rdata_q   <= '0;
            an_q      <= {DIGITS{INV}};
            seg_q     <= {8{INV}};
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            scan_q    <= scan_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            value_q   <= value_d;
            en_q      <= en_d;
            blink_q   <= blink_d;
            blank_q   <= blank_d;
            dp_q      <= dp_d;
            rdata_q   <= rdata_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign rdata        = rdata_q;
    assign led_data     = led_q;
    assign segment_data = seg_q;
    assign AN           = an_q;

endmodule

// File: tb/tb_seg_led_ctrl.sv
// Directed testbench for seg_led_ctrl: main instance (4 digits, active-low) and a
// 1-digit active-high corner instance.
module tb_seg_led_ctrl;

    logic        clk;
    logic        rst, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic [7:0]  led, seg;
    logic [3:0]  an;

    logic        rst_c, we_c;
    logic [1:0]  addr_c;
    logic [31:0] wdata_c, rdata_c;
    logic [7:0]  led_c, seg_c;
    logic [0:0]  an_c;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [3:0] SCAN_AN  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] SCAN_SEG [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
    localparam logic [3:0] BLNK_AN  [4] = '{4'hE, 4'hD, 4'hF, 4'h7};
    localparam logic [7:0] BLNK_SEG [4] = '{8'h8E, 8'h30, 8'hFF, 8'hF9};

    seg_led_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_SCANS(2), .LED_W(8), .ACTIVE_LOW(1)) u_dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .led_data(led), .segment_data(seg), .AN(an)
    );

    seg_led_ctrl #(.DIGITS(1), .REFRESH_DIV(4), .BLINK_SCANS(2), .LED_W(8), .ACTIVE_LOW(0)) u_corner (
        .clk(clk), .rst(rst_c), .we(we_c), .addr(addr_c), .wdata(wdata_c), .rdata(rdata_c),
        .led_data(led_c), .segment_data(seg_c), .AN(an_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    // Advance until AN moves from from_an to E (start of digit 0); bounded.
    task automatic sync_to(input logic [3:0] from_an, input int limit, input string tag);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < limit; i++) begin
            step();
            if (prev === from_an && an === 4'hE) begin
                found = 1'b1;
                break;
            end
            prev = an;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL %s_sync: no AN %h->E within %0d cycles, AN=%h", tag, from_an, limit, an);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        repeat (3) step();
        n_vec++; if (an !== 4'hF) begin n_err++; $display("FAIL reset_an: got %h want F", an); end
        n_vec++; if (seg !== 8'hFF) begin n_err++; $display("FAIL reset_seg: got %h want FF", seg); end
        n_vec++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led: got %h want 00", led); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst = 1'b1;
        step();
        n_vec++; if (an !== 4'hE) begin n_err++; $display("FAIL release_an: got %h want E", an); end
        n_vec++; if (seg !== 8'hC0) begin n_err++; $display("FAIL release_seg: got %h want C0", seg); end
    endtask

    task automatic test_scan();
        wr(2'd1, 32'h0000_1A3F);
        sync_to(4'h7, 40, "scan");
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                n_vec++; if (an !== SCAN_AN[d]) begin n_err++; $display("FAIL scan_an d%0d c%0d: got %h want %h", d, c, an, SCAN_AN[d]); end
                n_vec++; if (seg !== SCAN_SEG[d]) begin n_err++; $display("FAIL scan_seg d%0d c%0d: got %h want %h", d, c, seg, SCAN_SEG[d]); end
                step();
            end
        end
        n_vec++; if (an !== 4'hE) begin n_err++; $display("FAIL scan_wrap: got %h want E", an); end
    endtask

    task automatic test_blank_dp();
        wr(2'd2, 32'h0002_0401);
        sync_to(4'h7, 40, "blank");
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                n_vec++; if (an !== BLNK_AN[d]) begin n_err++; $display("FAIL blank_an d%0d c%0d: got %h want %h", d, c, an, BLNK_AN[d]); end
                n_vec++; if (seg !== BLNK_SEG[d]) begin n_err++; $display("FAIL blank_seg d%0d c%0d: got %h want %h", d, c, seg, BLNK_SEG[d]); end
                step();
            end
        end
    endtask

    task automatic test_blink();
        wr(2'd2, 32'h0000_0003);
        addr = 2'd3;
        sync_to(4'hF, 100, "blink");
        for (int c = 0; c < 32; c++) begin
            n_vec++; if (an !== SCAN_AN[(c/4)%4]) begin n_err++; $display("FAIL blink_on_an c%0d: got %h want %h", c, an, SCAN_AN[(c/4)%4]); end
            n_vec++; if (rdata !== 32'((c/4)%4)) begin n_err++; $display("FAIL blink_on_status c%0d: got %h want %h", c, rdata, 32'((c/4)%4)); end
            step();
        end
        for (int c = 0; c < 32; c++) begin
            n_vec++; if (an !== 4'hF) begin n_err++; $display("FAIL blink_off_an c%0d: got %h want F", c, an); end
            n_vec++; if (seg !== 8'hFF) begin n_err++; $display("FAIL blink_off_seg c%0d: got %h want FF", c, seg); end
            n_vec++; if (rdata !== 32'(8 + (c/4)%4)) begin n_err++; $display("FAIL blink_off_status c%0d: got %h want %h", c, rdata, 32'(8 + (c/4)%4)); end
            step();
        end
        n_vec++; if (an !== 4'hE) begin n_err++; $display("FAIL blink_resume_an: got %h want E", an); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL blink_resume_status: got %h want 0", rdata); end
    endtask

    task automatic test_readback();
        wr(2'd0, 32'h0000_00A5);
        n_vec++; if (led !== 8'hA5) begin n_err++; $display("FAIL led_write: got %h want A5", led); end
        addr = 2'd0; step();
        n_vec++; if (rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_led: got %h want A5", rdata); end
        addr = 2'd1; step();
        n_vec++; if (rdata !== 32'h0000_1A3F) begin n_err++; $display("FAIL rd_value: got %h want 1A3F", rdata); end
        wr(2'd2, 32'hFFFF_FF01);
        addr = 2'd2; step();
        n_vec++; if (rdata !== 32'h000F_0F01) begin n_err++; $display("FAIL rd_ctrl_mask: got %h want 000F0F01", rdata); end
        n_vec++; if (an !== 4'hF) begin n_err++; $display("FAIL all_blank_an: got %h want F", an); end
        wr(2'd2, 32'h0000_0001);
        addr = 2'd3;
        sync_to(4'h7, 40, "readback");
        for (int c = 0; c < 16; c++) begin
            n_vec++; if ((rdata & 32'hFFFF_FFF7) !== 32'(c/4)) begin n_err++; $display("FAIL rd_status c%0d: got %h want idx %0d", c, rdata, c/4); end
            n_vec++; if (an !== SCAN_AN[c/4]) begin n_err++; $display("FAIL rd_scan_an c%0d: got %h want %h", c, an, SCAN_AN[c/4]); end
            if (c == 6) begin wdata = 32'hFFFF_FFFF; we = 1'b1; end
            else we = 1'b0;
            step();
        end
        we = 1'b0;
    endtask

    task automatic test_reset_mid();
        sync_to(4'h7, 40, "midreset");
        repeat (8) step();
        n_vec++; if (an !== 4'hB) begin n_err++; $display("FAIL mid_pre_an: got %h want B", an); end
        rst = 1'b0; step();
        n_vec++; if (an !== 4'hF) begin n_err++; $display("FAIL mid_an: got %h want F", an); end
        n_vec++; if (seg !== 8'hFF) begin n_err++; $display("FAIL mid_seg: got %h want FF", seg); end
        n_vec++; if (led !== 8'h00) begin n_err++; $display("FAIL mid_led: got %h want 00", led); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mid_rdata: got %h want 0", rdata); end
        rst = 1'b1; step();
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (an !== 4'hE) begin n_err++; $display("FAIL mid_restart_an c%0d: got %h want E", c, an); end
            n_vec++; if (seg !== 8'hC0) begin n_err++; $display("FAIL mid_restart_seg c%0d: got %h want C0", c, seg); end
            step();
        end
        n_vec++; if (an !== 4'hD) begin n_err++; $display("FAIL mid_next_an: got %h want D", an); end
        n_vec++; if (seg !== 8'hC0) begin n_err++; $display("FAIL mid_next_seg: got %h want C0", seg); end
    endtask

    task automatic test_param_corner();
        n_vec++; if (an_c !== 1'b0) begin n_err++; $display("FAIL corner_reset_an: got %h want 0", an_c); end
        n_vec++; if (seg_c !== 8'h00) begin n_err++; $display("FAIL corner_reset_seg: got %h want 00", seg_c); end
        rst_c = 1'b1; step();
        for (int c = 0; c < 12; c++) begin
            n_vec++; if (an_c !== 1'b1) begin n_err++; $display("FAIL corner_an c%0d: got %h want 1", c, an_c); end
            n_vec++; if (seg_c !== 8'h3F) begin n_err++; $display("FAIL corner_seg c%0d: got %h want 3F", c, seg_c); end
            step();
        end
        addr_c = 2'd1; wdata_c = 32'h0000_1A3F; we_c = 1'b1; step();
        we_c = 1'b0; addr_c = 2'd3; step();
        for (int c = 0; c < 12; c++) begin
            n_vec++; if (an_c !== 1'b1) begin n_err++; $display("FAIL corner_val_an c%0d: got %h want 1", c, an_c); end
            n_vec++; if (seg_c !== 8'h71) begin n_err++; $display("FAIL corner_val_seg c%0d: got %h want 71", c, seg_c); end
            n_vec++; if ((rdata_c & 32'hFFFF_FFF7) !== 32'h0) begin n_err++; $display("FAIL corner_status c%0d: got %h want idx 0", c, rdata_c); end
            step();
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        rst_c = 1'b0; we_c = 1'b0; addr_c = 2'd0; wdata_c = '0;
        test_reset();
        test_scan();
        test_blank_dp();
        test_blink();
        test_readback();
        test_reset_mid();
        test_param_corner();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
